// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sub_pkg
//  Description : Shared FSM state encoding and counter sizing for the
//                bit-serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 32;
    localparam int CNT_W_MAX = $clog2(MAX_WIDTH);

    // Bits needed to count bit positions 0..w-1.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : One-bit full subtractor cell, d = x - y - bin.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial a - b, LSB first, one bit per clock with a
//                start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_ff_q, borrow_ff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             slice_d, slice_bout;

    full_subtractor u_slice (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (borrow_ff_q),
        .d    (slice_d),
        .bout (slice_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            res_q       <= '0;
            diff_q      <= '0;
            cnt_q       <= '0;
            borrow_ff_q <= 1'b0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            res_q       <= res_d;
            diff_q      <= diff_d;
            cnt_q       <= cnt_d;
            borrow_ff_q <= borrow_ff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        res_d       = res_q;
        diff_d      = diff_q;
        cnt_d       = cnt_q;
        borrow_ff_d = borrow_ff_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sr_d      = a;
                    b_sr_d      = b;
                    res_d       = '0;
                    cnt_d       = '0;
                    borrow_ff_d = 1'b0;
                    state_d     = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                res_d       = {slice_d, res_q[WIDTH-1:1]};
                a_sr_d      = a_sr_q >> 1;
                b_sr_d      = b_sr_q >> 1;
                borrow_ff_d = slice_bout;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // The slice is on the sign bits here, so overflow is
                    // judged from the cell inputs and output directly.
                    diff_d   = {slice_d, res_q[WIDTH-1:1]};
                    borrow_d = slice_bout;
                    ovf_d    = (a_sr_q[0] ^ b_sr_q[0]) & (slice_d ^ a_sr_q[0]);
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule
`default_nettype wire
